// File: rtl/dma_packet_framer.sv
// -----------------------------------------------------------------------------
// dma_packet_framer
//
// Drains every sensor payload from the multiport sensor memory when the memory
// raises SoT_to_DMA. The payload is wrapped into a single outgoing frame and
// streamed to the TX serializer byte by byte. EoT_ok_rx is pulsed once the
// last byte has been accepted.
//
// Frame layout:
//   SYNC_BYTE | SENSORS | ok_rx status | payload bytes ... | CRC[15:8] | CRC[7:0]
// The CRC-16/CCITT covers the header byte through the last payload byte. The
// sync byte is not included.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   pon            asynchronous active-high reset
//   SoT_to_DMA     start-of-transfer pulse, accepted only when idle
//   rd_en          memory read issued this cycle (data valid next cycle)
//   data_from_mem  RAM read data, one cycle after rd_en
//   EoR_from_Mem   marks the rd_en of the last payload byte
//   ok_rx          per-sensor CRC-ok flags, latched at SoT
//   sink_ready     permits memory reads (keeps one FIFO slot for the in-flight read)
//   tx_data/valid/ready/last  AXI-style byte stream to the serializer
//   EoT_ok_rx      one-cycle pulse once the frame has been sent
//   busy           high from SoT acceptance until EoT_ok_rx
//   len_err        sticky payload-length / overflow error, cleared by the next SoT
// -----------------------------------------------------------------------------
module dma_packet_framer #(
  parameter int          SENSORS       = 2,
  parameter int          PAYLOAD_BYTES = 3,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter logic [15:0] CRC_INIT      = 16'hFFFF,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               pon,
  input  logic               SoT_to_DMA,
  input  logic               rd_en,
  input  logic [7:0]         data_from_mem,
  input  logic               EoR_from_Mem,
  input  logic [SENSORS-1:0] ok_rx,
  output logic               sink_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               EoT_ok_rx,
  output logic               busy,
  output logic               len_err
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]     EXP_LEN = 16'(SENSORS * PAYLOAD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_HDR, ST_STAT, ST_PAYLOAD, ST_CRC_H, ST_CRC_L, ST_DONE
  } state_e;

  // CRC-16/CCITT, polynomial 0x1021, one byte per call, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [SENSORS-1:0] stat_q, stat_d;
  logic [15:0]        crc_q, crc_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               len_err_q, len_err_d;
  logic               eor_seen_q, eor_seen_d;
  logic               rd_en_d_q, rd_en_d_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [7:0]         fifo_mem [FIFO_DEPTH];

  logic               busy_w;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_free;
  logic [7:0]         fifo_head;
  logic               pop;
  logic               push;
  logic               drop;

  // busy covers SYNC..CRC_L; it is already low in the DONE cycle.
  assign busy_w     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_free  = DEPTH_C - fifo_cnt_q;
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // A read issued now lands one cycle later. Requiring two free slots keeps
  // room for that in-flight byte.
  assign sink_ready = busy_w && !eor_seen_q && (fifo_free >= CNT_W'(2));

  // Pop frees a slot in the same cycle, so a push into a full FIFO that is
  // popping is still accepted. There is no bypass when the FIFO is empty.
  assign pop  = (state_q == ST_PAYLOAD) && !fifo_empty && tx_ready;
  assign push = rd_en_d_q && ((fifo_cnt_q != DEPTH_C) || pop);
  assign drop = rd_en_d_q && !push;

  assign busy    = busy_w;
  assign len_err = len_err_q;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    stat_d     = stat_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q + 16'(push);
    len_err_d  = len_err_q | drop;
    eor_seen_d = eor_seen_q | (EoR_from_Mem & busy_w);
    rd_en_d_d  = rd_en & busy_w;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;
    EoT_ok_rx  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (SoT_to_DMA) begin
          state_d    = ST_SYNC;
          stat_d     = ok_rx;
          crc_d      = CRC_INIT;
          cnt_d      = '0;
          len_err_d  = 1'b0;
          eor_seen_d = 1'b0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          fifo_cnt_d = '0;
        end
      end
      ST_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_d = ST_HDR;
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = 8'(SENSORS);
        if (tx_ready) begin
          crc_d   = crc16_byte(crc_q, tx_data);
          state_d = ST_STAT;
        end
      end
      ST_STAT: begin
        tx_valid = 1'b1;
        tx_data  = 8'(stat_q);
        if (tx_ready) begin
          crc_d   = crc16_byte(crc_q, tx_data);
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        tx_valid = !fifo_empty;
        tx_data  = fifo_head;
        if (pop) crc_d = crc16_byte(crc_q, fifo_head);
        // Leave only when the last read has landed and has been sent.
        if (eor_seen_q && fifo_empty && !rd_en_d_q) begin
          state_d   = ST_CRC_H;
          len_err_d = len_err_d | (cnt_q != EXP_LEN);
        end
      end
      ST_CRC_H: begin
        tx_valid = 1'b1;
        tx_data  = crc_q[15:8];
        if (tx_ready) state_d = ST_CRC_L;
      end
      ST_CRC_L: begin
        tx_valid = 1'b1;
        tx_data  = crc_q[7:0];
        tx_last  = 1'b1;
        if (tx_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        EoT_ok_rx = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge pon) begin
    if (pon) begin
      state_q    <= ST_IDLE;
      stat_q     <= '0;
      crc_q      <= CRC_INIT;
      cnt_q      <= '0;
      len_err_q  <= 1'b0;
      eor_seen_q <= 1'b0;
      rd_en_d_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      len_err_q  <= len_err_d;
      eor_seen_q <= eor_seen_d;
      rd_en_d_q  <= rd_en_d_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // NOTE: FIFO storage has no reset. The pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= data_from_mem;
  end

endmodule
